// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: sensor sync/debounce, entrance/exit gate FSMs
// and a saturating occupancy counter.
module parking_gate_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CAPACITY        = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ent_sensor,
  input  logic exit_sensor,
  output logic open_ent,
  output logic open_exit,
  output logic enter,
  output logic exit,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic full
);

  localparam int OW = $clog2(CAPACITY+1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
  localparam int HW = $clog2(HOLD_CYCLES+1);
  localparam logic [OW-1:0] CAP = OW'(CAPACITY);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES-1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES-1);

  typedef enum logic [1:0] {IDLE, OPEN, HOLD, WAIT} gate_t;

  // index 0 = entrance, 1 = exit
  logic [1:0] raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0] filt_q, filt_d;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;

  gate_t en_q, en_d, ex_q, ex_d;
  logic [HW-1:0] ehold_q, ehold_d, xhold_q, xhold_d;
  logic en_fire, ex_fire, en_ok, ex_ok;
  logic [OW-1:0] occ_q, occ_d;
  logic full_q, full_d;
  logic oe_q, ox_q, enter_q, exit_q;

  assign raw = {exit_sensor, ent_sensor};

  always_comb begin
    filt_d = filt_q;
    dcnt_d = dcnt_q;
    for (int s = 0; s < 2; s++) begin
      if (sync_q[s][SYNC_STAGES-1] == filt_q[s]) begin
        dcnt_d[s] = '0;
      end else if (dcnt_q[s] == DB_LAST) begin
        filt_d[s] = ~filt_q[s];
        dcnt_d[s] = '0;
      end else begin
        dcnt_d[s] = dcnt_q[s] + 1'b1;
      end
    end
  end

  always_comb begin
    en_d    = en_q;
    ehold_d = ehold_q;
    en_fire = 1'b0;
    unique case (en_q)
      IDLE: if (filt_q[0]) en_d = full_q ? WAIT : OPEN;
      WAIT: begin
        if (!filt_q[0]) en_d = IDLE;
        else if (!full_q) en_d = OPEN;
      end
      OPEN: begin
        if (!filt_q[0]) begin
          en_d    = HOLD;
          ehold_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (filt_q[0]) begin
          en_d = OPEN;
        end else if (ehold_q == '0) begin
          en_d    = IDLE;
          en_fire = 1'b1;
        end else begin
          ehold_d = ehold_q - 1'b1;
        end
      end
      default: en_d = IDLE;
    endcase
  end

  always_comb begin
    ex_d    = ex_q;
    xhold_d = xhold_q;
    ex_fire = 1'b0;
    unique case (ex_q)
      IDLE: if (filt_q[1]) ex_d = OPEN;
      OPEN: begin
        if (!filt_q[1]) begin
          ex_d    = HOLD;
          xhold_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (filt_q[1]) begin
          ex_d = OPEN;
        end else if (xhold_q == '0) begin
          ex_d    = IDLE;
          ex_fire = 1'b1;
        end else begin
          xhold_d = xhold_q - 1'b1;
        end
      end
      default: ex_d = IDLE;
    endcase
  end

  // An exit frees a space, so a full lot still accepts a simultaneous entry
  assign ex_ok = ex_fire && (occ_q != '0);
  assign en_ok = en_fire && ((occ_q != CAP) || ex_ok);

  always_comb begin
    occ_d = occ_q;
    if (en_ok && !ex_ok) occ_d = occ_q + 1'b1;
    else if (ex_ok && !en_ok) occ_d = occ_q - 1'b1;
    full_d = (occ_d == CAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      filt_q  <= '0;
      dcnt_q  <= '0;
      en_q    <= IDLE;
      ex_q    <= IDLE;
      ehold_q <= '0;
      xhold_q <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      oe_q    <= 1'b0;
      ox_q    <= 1'b0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        sync_q[s][0] <= raw[s];
        for (int i = 1; i < SYNC_STAGES; i++)
          sync_q[s][i] <= sync_q[s][i-1];
      end
      filt_q  <= filt_d;
      dcnt_q  <= dcnt_d;
      en_q    <= en_d;
      ex_q    <= ex_d;
      ehold_q <= ehold_d;
      xhold_q <= xhold_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
      oe_q    <= (en_d == OPEN) || (en_d == HOLD);
      ox_q    <= (ex_d == OPEN) || (ex_d == HOLD);
      enter_q <= en_ok;
      exit_q  <= ex_ok;
    end
  end

  assign open_ent  = oe_q;
  assign open_exit = ox_q;
  assign enter     = enter_q;
  assign exit      = exit_q;
  assign occupancy = occ_q;
  assign full      = full_q;

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per raw sensor input.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles before the filtered sensor value changes.
REQ-003 Parameter HOLD_CYCLES, default 8: cycles a gate stays open after its sensor clears.
REQ-004 Parameter CAPACITY, default 3: number of parking spaces.
REQ-005 Port clk, input, 1: single clock; all state on its rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port ent_sensor, input, 1: raw asynchronous entrance presence sensor, 1 = car present.
REQ-008 Port exit_sensor, input, 1: raw asynchronous exit presence sensor, 1 = car present.
REQ-009 Port open_ent, output, 1: entrance gate open command.
REQ-010 Port open_exit, output, 1: exit gate open command.
REQ-011 Port enter, output, 1: one-cycle pulse per completed entry; feeds the downstream parking control enter input.
REQ-012 Port exit, output, 1: one-cycle pulse per completed exit; feeds the downstream parking control exit input.
REQ-013 Port occupancy, output, $clog2(CAPACITY+1): cars currently inside.
REQ-014 Port full, output, 1: high when occupancy == CAPACITY.

Function
REQ-015 Each raw sensor SHALL pass through a SYNC_STAGES flop synchronizer before any other use.
REQ-016 Per sensor, a debounce counter SHALL update the filtered value on the edge where the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any match in between SHALL clear the counter.
REQ-017 Each gate SHALL have an independent registered FSM with states IDLE, OPEN, HOLD; the entrance FSM SHALL add state WAIT.
REQ-018 IDLE -> OPEN when the filtered sensor is 1; for the entrance, IDLE -> WAIT instead when full is 1.
REQ-019 WAIT -> OPEN when full falls while the filtered sensor is 1; WAIT -> IDLE when the filtered sensor is 0; no pulse on WAIT -> IDLE.
REQ-020 OPEN -> HOLD when the filtered sensor is 0; the hold counter SHALL load HOLD_CYCLES-1.
REQ-021 In HOLD, the hold counter SHALL decrement each cycle.
REQ-022 In HOLD, if the filtered sensor returns to 1, the FSM SHALL go to OPEN with no pulse.
REQ-023 HOLD -> IDLE when the hold counter is 0; on that edge the gate's enter/exit output SHALL pulse high for exactly one cycle.
REQ-024 open_ent and open_exit SHALL be registered and equal 1 exactly in states OPEN and HOLD.
REQ-025 Latency: open asserts on the edge after the filtered sensor rises; the pulse occurs HOLD_CYCLES cycles after the HOLD entry edge.
REQ-026 The exit FSM SHALL open the gate regardless of occupancy.
REQ-027 The exit pulse SHALL be suppressed when occupancy is 0; the counter SHALL never underflow.
REQ-028 Occupancy update: enter only -> +1; exit only -> -1; both on the same edge -> unchanged.
REQ-029 Occupancy SHALL saturate at CAPACITY; an enter pulse SHALL be suppressed when occupancy == CAPACITY and no simultaneous exit occurs.
REQ-030 full SHALL be registered and consistent with occupancy in the same cycle.

Reset
REQ-031 Asserting reset_n low SHALL asynchronously clear all of: synchronizers, filtered values, debounce/hold counters, FSMs (to IDLE), occupancy, open_ent, open_exit, enter, exit, full.
REQ-032 Reset asserted mid-operation SHALL abort any open or hold sequence with no pulse; after release, a sensor still held high SHALL be re-debounced from 0.
REQ-033 After release, the first state change SHALL occur no earlier than the first rising clk edge following release.

Verification (defaults)
REQ-034 ent_sensor high 10 cycles, then low -> open_ent high about 7 cycles after rise (2 sync + 4 debounce + 1); enter pulses once, 8 cycles after HOLD entry; occupancy 0->1.
REQ-035 ent_sensor glitch high 3 cycles -> no open_ent, no enter, occupancy unchanged.
REQ-036 Three full entries -> occupancy 3, full 1; fourth car -> entrance in WAIT, open_ent 0; one exit completes -> full 0, entrance opens, occupancy returns to 3.
REQ-037 exit_sensor cycle at occupancy 0 -> open_exit asserts; exit pulse suppressed; occupancy stays 0.
REQ-038 Entrance and exit HOLD expiring on the same edge at occupancy 1 -> enter and exit both pulse, occupancy stays 1.
REQ-039 Sensor re-asserted during HOLD -> back to OPEN, no pulse; reset_n low during OPEN -> all outputs 0 immediately.
